control_sequencer: RTL and testbench

//  Multi-cycle control unit upstream of the select/encode stage. Fetches via PC/MAR/MDR and

---
 rtl/control_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute sequencer driving datapath strobes per T-step.
// Latency: one T-step per cycle; an instruction takes 4..8 steps, memory steps may stretch.
// Backpressure: with MEM_WAIT_EN defined, T1 / ld T6 / st T7 hold until mem_ready=1; otherwise none.
module control_sequencer #(
  parameter int OPW    = 5,
  parameter int STEP_W = 3
) (
  input  logic            clock,
  input  logic            clear_n,
  input  logic [31:0]     ir,
  input  logic            con_ff,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Cout,
  output logic            PCin,
  output logic            IRin,
  output logic            MARin,
  output logic            MDRin,
  output logic            Yin,
  output logic            Zin,
  output logic            CONin,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic [OPW-1:0]  alu_op,
  output logic            run,
  output logic            illegal_op
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);
  localparam logic [STEP_W-1:0] T5 = STEP_W'(5);
  localparam logic [STEP_W-1:0] T6 = STEP_W'(6);
  localparam logic [STEP_W-1:0] T7 = STEP_W'(7);

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10010);
  localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10011);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  state_t            r_state, w_state_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic [OPW-1:0]    w_opc;
  logic [OPW-1:0]    w_imm_alu;
  logic              w_mem_wait;
  logic              w_unused;

  assign w_opc     = ir[31 -: OPW];
  assign w_imm_alu = (w_opc == OP_ADDI) ? OP_ADD : (w_opc == OP_ANDI) ? OP_AND : OP_OR;
  assign w_unused  = ^{mem_ready, ir[31-OPW:0]};

  // Memory steps stall only when the wait feature is built in.
`ifdef MEM_WAIT_EN
  assign w_mem_wait = ~mem_ready;
`else
  assign w_mem_wait = 1'b0;
`endif

  // State and T-step registers; synchronous reset wins over everything.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state <= ST_RUN;
      r_step  <= T0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Next-step selection and Moore strobe decode of (step, opcode); strobes low in reset and HALT.
  always_comb begin
    {PCout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin,
     CONin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    alu_op      = '0;
    run         = 1'b0;
    illegal_op  = 1'b0;
    w_step_nxt  = r_step;
    w_state_nxt = r_state;

    if (clear_n && (r_state == ST_RUN)) begin
      run = 1'b1;
      case (r_step)
        T0: begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
          w_step_nxt = T1;
        end
        T1: begin
          Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
          w_step_nxt = w_mem_wait ? T1 : T2;
        end
        T2: begin
          MDRout = 1'b1; IRin = 1'b1;
          w_step_nxt = T3;
        end
        default: begin
          // Final step of every sequence falls back to T0 unless told otherwise.
          w_step_nxt = T0;
          case (w_opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              case (r_step)
                T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; w_step_nxt = T4; end
                T4: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_opc; w_step_nxt = T5; end
                T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
              endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
              case (r_step)
                T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; w_step_nxt = T4; end
                T4: begin Cout = 1'b1; Zin = 1'b1; alu_op = w_imm_alu; w_step_nxt = T5; end
                T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
              endcase
            end
            OP_LDI, OP_LD, OP_ST: begin
              // All three form the effective address as Rb (or 0 via BAout) + C.
              case (r_step)
                T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; w_step_nxt = T4; end
                T4: begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; w_step_nxt = T5; end
                T5: begin
                  Zlowout = 1'b1;
                  if (w_opc == OP_LDI) begin
                    Gra = 1'b1; Rin = 1'b1;
                  end else begin
                    MARin = 1'b1; w_step_nxt = T6;
                  end
                end
                T6: begin
                  if (w_opc == OP_LD) begin
                    Read = 1'b1; MDRin = 1'b1;
                    w_step_nxt = w_mem_wait ? T6 : T7;
                  end else if (w_opc == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    w_step_nxt = T7;
                  end
                end
                T7: begin
                  if (w_opc == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                  end else if (w_opc == OP_ST) begin
                    Write = 1'b1;
                    w_step_nxt = w_mem_wait ? T7 : T0;
                  end
                end
                default: ;
              endcase
            end
            OP_BR: begin
              case (r_step)
                T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; w_step_nxt = T4; end
                T4: begin PCout = 1'b1; Yin = 1'b1; w_step_nxt = T5; end
                T5: begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; w_step_nxt = T6; end
                T6: begin Zlowout = 1'b1; PCin = con_ff; end
                default: ;
              endcase
            end
            OP_JR: begin
              if (r_step == T3) begin
                Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
              end
            end
            OP_NOP: ;
            OP_HALT: begin
              w_state_nxt = ST_HALT;
            end
            default: begin
              illegal_op = (r_step == T3);
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized and directed stimulus against a per-instruction step-table model.
// Latency: model expects one step per cycle, plus stall cycles on memory steps when MEM_WAIT_EN is set.
// Backpressure: mem_ready is driven low/high by the bench to exercise stalls on memory steps.
module tb_control_sequencer;

  logic        clock;
  logic        clear_n;
  logic [31:0] ir;
  logic        con_ff;
  logic        mem_ready;
  logic        PCout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin;
  logic        CONin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0]  alu_op;
  logic        run;
  logic        illegal_op;

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe masks, bit 0 = PCout ... bit 19 = BAout.
  localparam logic [19:0] M_PCOUT   = 20'h00001;
  localparam logic [19:0] M_ZLOWOUT = 20'h00002;
  localparam logic [19:0] M_MDROUT  = 20'h00004;
  localparam logic [19:0] M_COUT    = 20'h00008;
  localparam logic [19:0] M_PCIN    = 20'h00010;
  localparam logic [19:0] M_IRIN    = 20'h00020;
  localparam logic [19:0] M_MARIN   = 20'h00040;
  localparam logic [19:0] M_MDRIN   = 20'h00080;
  localparam logic [19:0] M_YIN     = 20'h00100;
  localparam logic [19:0] M_ZIN     = 20'h00200;
  localparam logic [19:0] M_CONIN   = 20'h00400;
  localparam logic [19:0] M_INCPC   = 20'h00800;
  localparam logic [19:0] M_READ    = 20'h01000;
  localparam logic [19:0] M_WRITE   = 20'h02000;
  localparam logic [19:0] M_GRA     = 20'h04000;
  localparam logic [19:0] M_GRB     = 20'h08000;
  localparam logic [19:0] M_GRC     = 20'h10000;
  localparam logic [19:0] M_RIN     = 20'h20000;
  localparam logic [19:0] M_ROUT    = 20'h40000;
  localparam logic [19:0] M_BAOUT   = 20'h80000;

  typedef struct packed {
    logic [19:0] s;
    logic [4:0]  alu;
    logic        mw;
    logic        ill;
  } step_t;

  step_t prog[$];

  control_sequencer dut (
    .clock(clock), .clear_n(clear_n), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .CONin(CONin),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .alu_op(alu_op), .run(run), .illegal_op(illegal_op)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {5'b0, BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, IncPC, CONin, Zin, Yin,
            MDRin, MARin, IRin, PCin, Cout, MDRout, Zlowout, PCout, alu_op, run, illegal_op};
  endfunction

  task automatic push(input logic [19:0] s, input logic [4:0] alu, input logic mw, input logic ill);
    step_t st;
    st = '{s: s, alu: alu, mw: mw, ill: ill};
    prog.push_back(st);
  endtask

  // Expected step sequence of one instruction, straight from the instruction table.
  task automatic build_prog(input logic [4:0] opc, input logic con, output logic is_halt);
    logic [4:0] ia;
    is_halt = 1'b0;
    prog.delete();
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd3, 1'b0, 1'b0);
    push(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b1, 1'b0);
    push(M_MDROUT | M_IRIN, 5'd0, 1'b0, 1'b0);
    ia = (opc == 5'd12) ? 5'd3 : (opc == 5'd13) ? 5'd5 : 5'd6;
    case (opc)
      5'd3, 5'd4, 5'd5, 5'd6: begin
        push(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0, 1'b0);
        push(M_GRC | M_ROUT | M_ZIN, opc, 1'b0, 1'b0);
        push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b0, 1'b0);
      end
      5'd12, 5'd13, 5'd14: begin
        push(M_GRB | M_ROUT | M_YIN, 5'd0, 1'b0, 1'b0);
        push(M_COUT | M_ZIN, ia, 1'b0, 1'b0);
        push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b0, 1'b0);
      end
      5'd1, 5'd0, 5'd2: begin
        push(M_GRB | M_BAOUT | M_YIN, 5'd0, 1'b0, 1'b0);
        push(M_COUT | M_ZIN, 5'd3, 1'b0, 1'b0);
        if (opc == 5'd1) begin
          push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 1'b0, 1'b0);
        end else begin
          push(M_ZLOWOUT | M_MARIN, 5'd0, 1'b0, 1'b0);
          if (opc == 5'd0) begin
            push(M_READ | M_MDRIN, 5'd0, 1'b1, 1'b0);
            push(M_MDROUT | M_GRA | M_RIN, 5'd0, 1'b0, 1'b0);
          end else begin
            push(M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b0, 1'b0);
            push(M_WRITE, 5'd0, 1'b1, 1'b0);
          end
        end
      end
      5'd18: begin
        push(M_GRA | M_ROUT | M_CONIN, 5'd0, 1'b0, 1'b0);
        push(M_PCOUT | M_YIN, 5'd0, 1'b0, 1'b0);
        push(M_COUT | M_ZIN, 5'd3, 1'b0, 1'b0);
        push(con ? (M_ZLOWOUT | M_PCIN) : M_ZLOWOUT, 5'd0, 1'b0, 1'b0);
      end
      5'd19: push(M_GRA | M_ROUT | M_PCIN, 5'd0, 1'b0, 1'b0);
      5'd26: push(20'h0, 5'd0, 1'b0, 1'b0);
      5'd27: begin
        push(20'h0, 5'd0, 1'b0, 1'b0);
        is_halt = 1'b1;
      end
      default: push(20'h0, 5'd0, 1'b0, 1'b1);
    endcase
  endtask

  task automatic check_invariants();
    check_eq("gr_onehot", 32'($countones({Gra, Grb, Grc}) <= 1), 32'd1);
    if (Gra | Grb | Grc)
      check_eq("rsel_onehot", 32'($countones({Rin, Rout, BAout})), 32'd1);
  endtask

  task automatic apply_reset(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      clear_n   = 1'b0;
      con_ff    = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check_eq("reset", obs_vec(), 32'h0);
    end
  endtask

  // fw >= 0 forces that many stall cycles on execute-phase memory steps (fetch T1 not stalled);
  // abort_at >= 0 asserts reset at the start of that step index instead of checking it.
  task automatic run_instr(input logic [31:0] iv, input logic con, input int fw, input int abort_at);
    logic hlt;
    int   nwait;
    build_prog(iv[31:27], con, hlt);
    foreach (prog[i]) begin
      if (i == abort_at) begin
        apply_reset(2);
        return;
      end
      nwait = 0;
`ifdef MEM_WAIT_EN
      if (prog[i].mw) nwait = (fw >= 0) ? ((i == 1) ? 0 : fw) : int'($urandom_range(0, 3));
`endif
      for (int w = 0; w <= nwait; w++) begin
        @(negedge clock);
        clear_n   = 1'b1;
        ir        = iv;
        con_ff    = con;
        mem_ready = 1'($urandom_range(0, 1));
`ifdef MEM_WAIT_EN
        if (prog[i].mw) mem_ready = (w == nwait);
`endif
        #1;
        check_eq($sformatf("op%0d_T%0d_w%0d", iv[31:27], i, w), obs_vec(),
                 {5'b0, prog[i].s, prog[i].alu, 1'b1, prog[i].ill});
        check_invariants();
      end
    end
    if (hlt) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clock);
        con_ff    = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check_eq("halt_idle", obs_vec(), 32'h0);
      end
      apply_reset(2);
    end
  endtask

  initial begin
    logic [4:0] opc;
    int         ab;
    clear_n   = 1'b0;
    ir        = 32'h0;
    con_ff    = 1'b0;
    mem_ready = 1'b0;

    apply_reset(2);
    run_instr(32'h18918000, 1'b0, -1, -1);  // add R1,R2,R3
    run_instr(32'h00900010, 1'b0,  3, -1);  // ld R1,0x10(R2), stalled 3 cycles in T6
    run_instr(32'h90800004, 1'b0, -1, -1);  // br, condition false
    run_instr(32'h90800004, 1'b1, -1, -1);  // br, condition true
    run_instr(32'hD8000000, 1'b0, -1, -1);  // halt, idle, then reset
    run_instr(32'hF8000000, 1'b0, -1, -1);  // undefined opcode
    run_instr(32'h18918000, 1'b0, -1, -1);  // fetch resumes at T0
    run_instr(32'h00900010, 1'b0,  2,  6);  // reset during ld T6
    run_instr(32'h10900010, 1'b0,  2, -1);  // st after the aborted ld
    run_instr(32'h60900007, 1'b0, -1, -1);  // addi
    run_instr(32'h08900007, 1'b0, -1, -1);  // ldi
    run_instr(32'h98800000, 1'b0, -1, -1);  // jr
    run_instr(32'hD0000000, 1'b0, -1, -1);  // nop

    for (int k = 0; k < 60; k++) begin
      opc = 5'($urandom_range(0, 31));
      ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr({opc, 27'($urandom)}, 1'($urandom_range(0, 1)), -1, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
